// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package bit_serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// 1-bit gate-level full adder; the single arithmetic slice of the serial adder.
module full_adder
  import bit_serial_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic ab_x;

  assign ab_x = a_i ^ b_i;
  assign s_o  = ab_x ^ ci_i;
  assign co_o = (a_i & b_i) | (ab_x & ci_i);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial a + b + cin, LSB first, one bit per clock through a single full adder.
// Optional BIT_SERIAL_ADDER_SUB_EN adds a 'sub' port for a - b - cin (two's complement).
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef BIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sbit,
  output logic             sbit_vld
);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q, sub_q, sub_in;
  logic             accept, last, fa_b, fa_s, fa_co;
  logic [WIDTH-1:0] res_d;

`ifdef BIT_SERIAL_ADDER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  assign accept = start && (state_q != ST_RUN);
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));
  assign fa_b   = b_sr_q[0] ^ sub_q;

  full_adder u_fa (
    .a_i (a_sr_q[0]),
    .b_i (fa_b),
    .ci_i(carry_q),
    .s_o (fa_s),
    .co_o(fa_co)
  );

  // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  assign res_d = (res_sr_q >> 1) | {fa_s, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      sub_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= res_d;
          carry_q  <= fa_co;
          cnt_q    <= cnt_q + 1'b1;
          if (last) begin
            state_q <= ST_DONE;
            sum_q   <= res_d;
            cout_q  <= fa_co;
          end
        end
        default: begin
          if (accept) begin
            state_q <= ST_RUN;
            a_sr_q  <= a;
            b_sr_q  <= b;
            // Subtraction is a + ~b + 1 - cin, so the initial carry becomes ~cin.
            carry_q <= cin ^ sub_in;
            sub_q   <= sub_in;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign sbit_vld = busy;
  assign sbit     = busy & fa_s;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and model-based checks for bit_serial_adder at WIDTH=8.
module tb_bit_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             cin = 1'b0;
  logic             sub_r = 1'b0;
  logic             busy, done, cout, sbit, sbit_vld;
  logic [WIDTH-1:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
`ifdef BIT_SERIAL_ADDER_SUB_EN
    .sub     (sub_r),
`endif
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .sbit    (sbit),
    .sbit_vld(sbit_vld)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation in the current cycle and check stream, latency and result.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tcin, input logic tsub,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                        input string tag);
    a = ta; b = tb; cin = tcin; sub_r = tsub; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      check({tag, "_vld"}, 32'(sbit_vld), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'(sbit_vld));
      check({tag, "_sbit"}, 32'(sbit), 32'(exp_sum[i]));
      check({tag, "_nodone"}, 32'(done), 32'd0);
      step();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check({tag, "_vld_off"}, 32'(sbit_vld), 32'd0);
  endtask

  initial begin
    logic [WIDTH:0] ref_v;
    logic [WIDTH-1:0] ra, rb;
    logic rc;
    int n;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_sbit", 32'(sbit), 32'd0);
    check("rst_vld", 32'(sbit_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 0x35 + 0x4A: stream 1,1,1,1,1,1,1,0
    run_op(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, "add_35_4a");

    // Back-to-back from the done cycle, with an ignored start mid-RUN
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    check("b2b_busy", 32'(busy), 32'd1);
    step(); n++;
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    step(); n++;
    start = 1'b0;
    check("b2b_hold_sum", 32'(sum), 32'h7F);
    check("b2b_still_run", 32'(busy), 32'd1);
    while (!done && n < 20) begin
      step(); n++;
    end
    check("b2b_spacing", 32'(n), 32'd9);
    check("b2b_sum", 32'(sum), 32'h30);
    check("b2b_cout", 32'(cout), 32'd0);
    step();
    check("b2b_idle", 32'(busy | done), 32'd0);

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "wrap");
    step();
    run_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, "cin_only");
    step();
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, "carry_chain");
    step();

    // Asynchronous reset in RUN cycle 4
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_vld", 32'(sbit_vld), 32'd0);
    check("arst_sbit", 32'(sbit), 32'd0);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("arst_nodone", 32'(done | busy), 32'd0);
    end
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, "post_rst");
    step();

`ifdef BIT_SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub_10_01");
    step();
    run_op(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, "sub_borrow");
    step();
`endif

    // Random operands, issued back-to-back from each done cycle
    for (int k = 0; k < 1000; k++) begin
      ra = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      rb = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      rc = 1'($urandom_range(0, 1));
      ref_v = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      run_op(ra, rb, rc, 1'b0, ref_v[WIDTH-1:0], ref_v[WIDTH], "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
